ahb_decoder_dphase: RTL
=======================

// Module: ahb_decoder_dphase
// PURPOSE
//  - Parametrised AHB address decoder for one master port of the generated interconnect.
//  - Address phase: combinational per-slave request from a parameter address map (inclusive bounds).
//  - Data phase: registered, HREADY-qualified slave select for the response mux.
//  - Built-in default slave returns a two-cycle ERROR response for unmapped NONSEQ/SEQ transfers.
// PARAMETERS
//  AHB_ADDR_WIDTH  32           address width
//  SLAVE_NUM       4            slaves reachable from this master, 1..16
//  SLV_LOW_ADDR    '0           packed [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0], inclusive low bound per slave
//  SLV_HIGH_ADDR   '1           packed [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0], inclusive high bound per slave
//  ERR_CNT_WIDTH   8            width of the saturating decode-error counter
// PORTS
//  hclk              in   1                clock
//  hreset_n          in   1                asynchronous active-low reset
//  haddr             in   AHB_ADDR_WIDTH   address-phase address
//  htrans            in   htrans_type      IDLE/BUSY/NONSEQ/SEQ (AHB_package)
//  hready            in   1                global HREADY (transfer accepted when 1)
//  hreq              out  SLAVE_NUM        address-phase slave select, one-hot or zero
//  default_slv_sel   out  1                address-phase select of default slave
//  hsel_dphase       out  SLAVE_NUM        data-phase slave select (response mux control)
//  default_dphase    out  1                default slave owns current data phase
//  default_hreadyout out  1                default slave HREADYOUT
//  default_hresp     out  1                default slave HRESP (0 OKAY, 1 ERROR)
//  dec_err_cnt       out  ERR_CNT_WIDTH    saturating count of unmapped transfers
// BEHAVIOUR
//  - match[i] = (haddr >= SLV_LOW_ADDR[i]) && (haddr <= SLV_HIGH_ADDR[i]), full-width compare.
//  - Overlap: lowest index wins; hreq is always one-hot or zero.
//  - active = (htrans == NONSEQ || htrans == SEQ).
//    - hreq = active ? match_onehot : '0.
//    - default_slv_sel = active && ~|match.
//  - IDLE/BUSY never assert any select and never raise an error.
//  - hsel_dphase/default_dphase register hreq/default_slv_sel only when hready=1; otherwise hold.
//  - Default slave FSM, states D_IDLE, D_ERR1, D_ERR2:
//    - D_IDLE: hreadyout=1, hresp=0.
//      - hready && default_slv_sel -> D_ERR1.
//    - D_ERR1: hreadyout=0, hresp=1; unconditionally -> D_ERR2.
//    - D_ERR2: hreadyout=1, hresp=1.
//      - hready && default_slv_sel -> D_ERR1 (back-to-back error).
//      - else -> D_IDLE.
//  - Mapped transfers never enter the FSM. Zero added latency: hreq is valid in the cycle of haddr.
//  - dec_err_cnt increments by 1 on each cycle with hready && default_slv_sel.
//    - Saturates at all-ones; no wrap.
//  - Reset values:
//    - hsel_dphase='0, default_dphase=0, FSM=D_IDLE.
//    - default_hreadyout=1, default_hresp=0, dec_err_cnt=0.
//    - hreq/default_slv_sel follow inputs combinationally.
//  - Reset asserted mid-error: FSM returns to D_IDLE immediately; the pending error is dropped.
//  - Simultaneous counter saturation and new error: counter holds at max.
//  - Regions are aligned by the generator; the RTL does no bound sanity checks beyond simulation asserts.
//    - Assert: SLV_LOW_ADDR[i] <= SLV_HIGH_ADDR[i].
// CONFIGURATION
//  - AHB_DEC_REMAP_EN defined:
//    - Adds input `hremap` (1 bit) after htrans.
//    - hremap=1: slave 0 additionally decodes [0, SLV_HIGH_ADDR[0]-SLV_LOW_ADDR[0]].
//    - Within that alias, slave 0 takes priority over every other match.
//    - hremap is sampled combinationally with haddr.
//  - AHB_DEC_REMAP_EN undefined: no hremap port; decode uses the parameter map only.
// TESTING
//  - Map S0=0x2000..0x23FF, S1=0x2400..0x24FF. NONSEQ 0x2404, hready=1:
//    -> hreq=0b10 same cycle; hsel_dphase=0b10 next cycle.
//  - NONSEQ 0x9000, hready=1: default_slv_sel=1.
//    -> next cycle hreadyout=0, hresp=1; following cycle hreadyout=1, hresp=1; then OKAY; dec_err_cnt=1.
//  - Two back-to-back unmapped NONSEQ, second presented in the D_ERR2 cycle:
//    -> ERR1, ERR2, ERR1, ERR2 with no OKAY gap; dec_err_cnt=2.
//  - BUSY/IDLE to 0x9000, and NONSEQ 0x2000 with hready=0 held 3 cycles:
//    -> no error, counter unchanged; hsel_dphase holds its previous value until hready=1.
//  - hreset_n low during D_ERR1:
//    -> asynchronously hreadyout=1, hresp=0, hsel_dphase=0, dec_err_cnt=0.
//  - ERR_CNT_WIDTH=2, five unmapped transfers -> dec_err_cnt=3.
//    - With AHB_DEC_REMAP_EN, hremap=1, NONSEQ 0x0010 -> hreq=0b01.

Source files
------------

// File: rtl/ahb_decoder_dphase.sv
// ahb_decoder_dphase
//   AHB address decoder for one master port of the generated interconnect.
//   - Address phase: combinational one-hot slave request from a parameter
//     address map (inclusive bounds, lowest index wins on overlap).
//   - Data phase: HREADY-qualified registered slave select for the response mux.
//   - Built-in default slave answering unmapped NONSEQ/SEQ transfers with a
//     two-cycle ERROR response, plus a saturating decode-error counter.
//
// Optional feature (macro AHB_DEC_REMAP_EN):
//   Adds input hremap. When hremap=1 slave 0 additionally decodes the alias
//   window [0, SLV_HIGH_ADDR[0]-SLV_LOW_ADDR[0]] with priority over all others.
//
// Ports
//   hclk, hreset_n     clock, asynchronous active-low reset
//   haddr, htrans      address-phase address and transfer type
//   hremap             alias enable (only with AHB_DEC_REMAP_EN)
//   hready             global HREADY, transfer accepted when 1
//   hreq               address-phase slave select, one-hot or zero
//   default_slv_sel    address-phase select of the default slave
//   hsel_dphase        data-phase slave select
//   default_dphase     default slave owns the current data phase
//   default_hreadyout  default slave HREADYOUT
//   default_hresp      default slave HRESP (0 OKAY, 1 ERROR)
//   dec_err_cnt        saturating count of unmapped accepted transfers

package AHB_package;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_type;
endpackage

module ahb_decoder_dphase
    import AHB_package::*;
#(
    parameter int unsigned AHB_ADDR_WIDTH = 32,
    parameter int unsigned SLAVE_NUM      = 4,
    parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] SLV_LOW_ADDR  = '0,
    parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] SLV_HIGH_ADDR = '1,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr,
    input  htrans_type                htrans,
`ifdef AHB_DEC_REMAP_EN
    input  logic                      hremap,
`endif
    input  logic                      hready,
    output logic [SLAVE_NUM-1:0]      hreq,
    output logic                      default_slv_sel,
    output logic [SLAVE_NUM-1:0]      hsel_dphase,
    output logic                      default_dphase,
    output logic                      default_hreadyout,
    output logic                      default_hresp,
    output logic [ERR_CNT_WIDTH-1:0]  dec_err_cnt
);

    typedef enum logic [1:0] {
        D_IDLE,
        D_ERR1,
        D_ERR2
    } dstate_t;

    logic [SLAVE_NUM-1:0] match;
    logic [SLAVE_NUM-1:0] match_onehot;
    logic                 found;
    logic                 active;
    logic                 alias_hit;
    logic                 err_accept;
    dstate_t              state, state_nxt;

    // ------------------------------------------------------------------
    // Address phase decode
    // ------------------------------------------------------------------
    assign active = (htrans == NONSEQ) || (htrans == SEQ);

`ifdef AHB_DEC_REMAP_EN
    localparam logic [AHB_ADDR_WIDTH-1:0] ALIAS_TOP = SLV_HIGH_ADDR[0] - SLV_LOW_ADDR[0];
    assign alias_hit = hremap && (haddr <= ALIAS_TOP);
`else
    assign alias_hit = 1'b0;
`endif

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            match[i] = (haddr >= SLV_LOW_ADDR[i]) && (haddr <= SLV_HIGH_ADDR[i]);
        end
    end

    // Priority pick: the alias window beats everything, otherwise the
    // lowest-index matching region wins.
    always_comb begin
        match_onehot = '0;
        found        = 1'b0;
        if (alias_hit) begin
            match_onehot[0] = 1'b1;
        end else begin
            for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
                if (match[i] && !found) begin
                    match_onehot[i] = 1'b1;
                    found           = 1'b1;
                end
            end
        end
    end

    assign hreq            = active ? match_onehot : '0;
    assign default_slv_sel = active && !alias_hit && !(|match);
    assign err_accept      = hready && default_slv_sel;

    // ------------------------------------------------------------------
    // Data phase select
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            hsel_dphase    <= '0;
            default_dphase <= 1'b0;
        end else if (hready) begin
            hsel_dphase    <= hreq;
            default_dphase <= default_slv_sel;
        end
    end

    // ------------------------------------------------------------------
    // Default slave FSM
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state <= D_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            D_IDLE:  state_nxt = err_accept ? D_ERR1 : D_IDLE;
            D_ERR1:  state_nxt = D_ERR2;
            D_ERR2:  state_nxt = err_accept ? D_ERR1 : D_IDLE;
            default: state_nxt = D_IDLE;
        endcase
    end

    always_comb begin
        default_hreadyout = 1'b1;
        default_hresp     = 1'b0;
        unique case (state)
            D_IDLE: begin
                default_hreadyout = 1'b1;
                default_hresp     = 1'b0;
            end
            D_ERR1: begin
                default_hreadyout = 1'b0;
                default_hresp     = 1'b1;
            end
            D_ERR2: begin
                default_hreadyout = 1'b1;
                default_hresp     = 1'b1;
            end
            default: begin
                default_hreadyout = 1'b1;
                default_hresp     = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Saturating decode-error counter
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            dec_err_cnt <= '0;
        end else if (err_accept && (dec_err_cnt != '1)) begin
            dec_err_cnt <= dec_err_cnt + 1'b1;
        end
    end

    // The generator guarantees well-formed regions; catch a bad map in simulation.
    always_ff @(posedge hclk) begin
        for (int unsigned i = 0; i < SLAVE_NUM; i++) begin
            assert (SLV_LOW_ADDR[i] <= SLV_HIGH_ADDR[i]);
        end
    end

endmodule
